// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one bit per clock.
// Optional macro MULDIV_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for i_start, operands latched on accept
// PREP  | absolute values, sign bookkeeping, counter load, divide-by-zero detect
// RUN   | one shift-add (multiply) or restoring-divide step per cycle
// FIX   | sign correction and HI/LO/dz writeback
// DONE  | o_done pulse, results valid
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_dz
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]         op;
    logic [WIDTH-1:0]   op1, op2;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg_q, neg_r, dz;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   abs1, abs2;
    logic               div_zero;
    logic [WIDTH:0]     rem_sh, diff;
    logic [WIDTH-1:0]   quot_sh;
    logic               borrow;
    logic [2*WIDTH-1:0] prod_nxt, prod_fix;
    logic [WIDTH-1:0]   quot, rem;
    logic               run_last;

    assign is_div    = op[1];
    assign is_signed = ~op[0];
    // The most negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
    assign abs1      = (is_signed && op1[WIDTH-1]) ? -op1 : op1;
    assign abs2      = (is_signed && op2[WIDTH-1]) ? -op2 : op2;
    assign div_zero  = is_div && (abs2 == '0);

    // Restoring divide step: acc holds {rem, quot}, mplier holds the divisor.
    assign rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign quot_sh   = {acc[WIDTH-2:0], 1'b0};
    assign diff      = rem_sh - {1'b0, mplier};
    assign borrow    = diff[WIDTH];

    assign prod_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign prod_fix  = neg_q ? -acc : acc;
    assign quot      = acc[WIDTH-1:0];
    assign rem       = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        run_last = (cnt == CW'(1));
`ifdef MULDIV_EARLY_TERM_EN
        if (!is_div && (mplier[WIDTH-1:1] == '0)) begin
            run_last = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        o_busy    = (state != S_IDLE);
        o_done    = (state == S_DONE);
        case (state)
            S_IDLE: if (i_start) state_nxt = S_PREP;
            S_PREP: state_nxt = div_zero ? S_FIX : S_RUN;
            S_RUN:  if (run_last) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            op     <= '0;
            op1    <= '0;
            op2    <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            o_hi   <= '0;
            o_lo   <= '0;
            o_dz   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        op  <= i_op;
                        op1 <= i_op1;
                        op2 <= i_op2;
                    end
                end
                S_PREP: begin
                    neg_q  <= is_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    neg_r  <= is_signed & op1[WIDTH-1];
                    dz     <= div_zero;
                    cnt    <= CW'(WIDTH);
                    mplier <= abs2;
                    mcand  <= {{WIDTH{1'b0}}, abs1};
                    acc    <= is_div ? {{WIDTH{1'b0}}, abs1} : '0;
                end
                S_RUN: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc <= {(borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                                quot_sh[WIDTH-1:1], ~borrow};
                    end else begin
                        acc    <= prod_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                S_FIX: begin
                    o_dz <= dz;
                    if (dz) begin
                        o_lo <= '1;
                        o_hi <= op1;
                    end else if (is_div) begin
                        o_lo <= neg_q ? -quot : quot;
                        o_hi <= neg_r ? -rem : rem;
                    end else begin
                        o_hi <= prod_fix[2*WIDTH-1:WIDTH];
                        o_lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32) against an arithmetic reference model.
// Latency expectations follow MULDIV_EARLY_TERM_EN when the bench is built with it.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1, op2;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_op    (op),
        .i_op1   (op1),
        .i_op2   (op2),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo),
        .o_dz    (dz)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic straight from the instruction definitions.
    function automatic void model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] e_hi, output logic [31:0] e_lo,
                                  output logic e_dz, output int e_lat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] mag;
        int          top;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_dz = 1'b0;
        e_lat = 35;
        case (m_op)
            2'b00: begin p = 64'(sa * sb); e_hi = p[63:32]; e_lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; e_hi = p[63:32]; e_lo = p[31:0]; end
            2'b10: begin
                if (b == 0) begin
                    e_dz = 1'b1; e_lo = 32'hFFFF_FFFF; e_hi = a;
                end else begin
                    q = sa / sb; r = sa % sb;
                    e_lo = q[31:0]; e_hi = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    e_dz = 1'b1; e_lo = 32'hFFFF_FFFF; e_hi = a;
                end else begin
                    e_lo = a / b; e_hi = a % b;
                end
            end
        endcase
        if (e_dz) e_lat = 3;
`ifdef MULDIV_EARLY_TERM_EN
        if (!m_op[1]) begin
            mag = (m_op == 2'b00 && b[31]) ? 32'(-sb) : b;
            top = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) top = i;
            e_lat = top + 1 + 3;
        end
`else
        mag = 32'd0;
        top = 0;
`endif
    endfunction

    // Issues one op at a negedge (DUT in IDLE), returns results at o_done and the latency in cycles.
    task automatic do_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r_hi, output logic [31:0] r_lo, output logic r_dz,
                         output int lat, output logic busy_ok, output logic hold_ok);
        logic [31:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        busy_ok = 1'b1; hold_ok = 1'b1; lat = -1;
        op = t_op; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); op1 = $urandom; op2 = $urandom;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin lat = n; break; end
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
        end
        r_hi = hi; r_lo = lo; r_dz = dz;
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; op1 = 32'h1234_5678; op2 = 32'h9abc_def0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, dz} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, want all zero", busy, done, dz, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  d_op;
        logic [31:0] a, b, x_hi, x_lo;
        logic        x_dz;
    } vec_t;

    task automatic test_directed();
        vec_t v[7];
        logic [31:0] r_hi, r_lo, m_hi, m_lo;
        logic r_dz, m_dz, b_ok, h_ok;
        int lat, m_lat;
        v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        v[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        v[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        v[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        v[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        v[5] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        v[6] = '{2'b01, 32'd1000,      32'd5,         32'd0,         32'd5000,      1'b0};
        for (int i = 0; i < 7; i++) begin
            do_op(v[i].d_op, v[i].a, v[i].b, r_hi, r_lo, r_dz, lat, b_ok, h_ok);
            model(v[i].d_op, v[i].a, v[i].b, m_hi, m_lo, m_dz, m_lat);
            n_cmp++;
            if (r_hi !== v[i].x_hi || r_lo !== v[i].x_lo || r_dz !== v[i].x_dz) begin
                n_bad++;
                $display("FAIL directed[%0d] result: hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                         i, r_hi, r_lo, r_dz, v[i].x_hi, v[i].x_lo, v[i].x_dz);
            end
            n_cmp++;
            if (lat !== m_lat) begin
                n_bad++;
                $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, m_lat);
            end
            n_cmp++;
            if (b_ok !== 1'b1 || h_ok !== 1'b1) begin
                n_bad++;
                $display("FAIL directed[%0d] busy/hold: busy_ok=%b hold_ok=%b, want 1 1", i, b_ok, h_ok);
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a, b, r_hi, r_lo, m_hi, m_lo;
        logic [1:0] t_op;
        logic r_dz, m_dz, b_ok, h_ok;
        int lat, m_lat;
        for (int i = 0; i < 60; i++) begin
            t_op = 2'($urandom);
            a = pick(); b = pick();
            do_op(t_op, a, b, r_hi, r_lo, r_dz, lat, b_ok, h_ok);
            model(t_op, a, b, m_hi, m_lo, m_dz, m_lat);
            n_cmp++;
            if (r_hi !== m_hi || r_lo !== m_lo || r_dz !== m_dz || lat !== m_lat || !b_ok || !h_ok) begin
                n_bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d busy_ok=%b hold_ok=%b, want hi=%h lo=%h dz=%b lat=%0d",
                         i, t_op, a, b, r_hi, r_lo, r_dz, lat, b_ok, h_ok, m_hi, m_lo, m_dz, m_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r_hi, r_lo, m_hi, m_lo;
        logic r_dz, m_dz, b_ok, h_ok;
        int lat, m_lat;
        logic [1:0] ops[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], 32'hDEAD_BEEF, 32'h0000_0013 + 32'(i), r_hi, r_lo, r_dz, lat, b_ok, h_ok);
            model(ops[i], 32'hDEAD_BEEF, 32'h0000_0013 + 32'(i), m_hi, m_lo, m_dz, m_lat);
            n_cmp++;
            if (r_hi !== m_hi || r_lo !== m_lo || r_dz !== m_dz || lat !== m_lat) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                         i, r_hi, r_lo, r_dz, lat, m_hi, m_lo, m_dz, m_lat);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int extra = 0;
        logic [31:0] r_hi, r_lo;
        op = 2'b11; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 10) begin
                start = 1'b1; op = 2'b01; op1 = 32'd3; op2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin lat = n; break; end
        end
        start = 1'b0;
        r_hi = hi; r_lo = lo;
        n_cmp++;
        if (r_hi !== 32'd2 || r_lo !== 32'd14 || lat !== 35) begin
            n_bad++;
            $display("FAIL ignore_start: hi=%0d lo=%0d lat=%0d, want hi=2 lo=14 lat=35", r_hi, r_lo, lat);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL ignore_start queued: %0d busy/done cycles after completion, want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        op = 2'b01; op1 = 32'h0001_0001; op2 = 32'hFFFF_0003; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, dz} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_abort: busy=%b done=%b dz=%b hi=%h lo=%h, want all zero", busy, done, dz, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_abort done: %0d busy/done cycles after abort, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
